// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, the shared-ALU arbiter and
// the response consumer.
interface alu_arbiter_if;
   logic       req0_valid;
   logic       req0_ready;
   logic [7:0] req0_a;
   logic [7:0] req0_b;
   logic [2:0] req0_op;

   logic       req1_valid;
   logic       req1_ready;
   logic [7:0] req1_a;
   logic [7:0] req1_b;
   logic [2:0] req1_op;

   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [7:0] rsp_result;
   logic [3:0] rsp_flags;
   logic       rsp_err;

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      input  rsp_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
   );

   // Requester/consumer side.
   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      output rsp_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
   );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between two requesters: arbitrate, latch operands, evaluate
// once, then hold a registered result/flags response until the consumer takes it.
module alu_arbiter #(
   parameter bit          FIXED_PRIORITY = 1'b0,
   parameter int unsigned LEGAL_OP_MAX   = 2
) (
   input  logic          clk,
   input  logic          reset,
   alu_arbiter_if.slave  bus,
   output logic          busy
);

   localparam logic [2:0] LegalOpMax = 3'(LEGAL_OP_MAX);
   localparam logic [2:0] OpPass     = 3'd0;
   localparam logic [2:0] OpAdd      = 3'd1;
   localparam logic [2:0] OpSub      = 3'd2;

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e     state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [2:0] op_q, op_d;
   logic       id_q, id_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       rsp_id_q, rsp_id_d;
   logic [7:0] rsp_result_q, rsp_result_d;
   logic [3:0] rsp_flags_q, rsp_flags_d;
   logic       rsp_err_q, rsp_err_d;

   logic       grant0, grant1;
   logic [8:0] sum, diff;
   logic [7:0] alu_result;
   logic       alu_carry, alu_ovf, alu_err;
   logic [3:0] alu_flags;

   // Grants only exist in idle; round-robin favours the requester not served last.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == StIdle) begin
         if (bus.req0_valid && bus.req1_valid) begin
            if (FIXED_PRIORITY || last_grant_q) grant0 = 1'b1;
            else                                grant1 = 1'b1;
         end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
         end
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   // SUB carry is the carry-out of a + ~b + 1, i.e. set when no borrow occurs.
   always_comb begin
      sum        = {1'b0, a_q} + {1'b0, b_q};
      diff       = {1'b0, a_q} + {1'b0, ~b_q} + 9'd1;
      alu_result = '0;
      alu_carry  = 1'b0;
      alu_ovf    = 1'b0;
      alu_err    = 1'b0;
      if (op_q > LegalOpMax) begin
         alu_err = 1'b1;
      end else begin
         case (op_q)
            OpPass: alu_result = b_q;
            OpAdd: begin
               alu_result = sum[7:0];
               alu_carry  = sum[8];
               alu_ovf    = (a_q[7] == b_q[7]) && (sum[7] != a_q[7]);
            end
            OpSub: begin
               alu_result = diff[7:0];
               alu_carry  = diff[8];
               alu_ovf    = (a_q[7] != b_q[7]) && (diff[7] != a_q[7]);
            end
            default: alu_err = 1'b1;
         endcase
      end
      alu_flags = alu_err ? 4'b0000
                          : {alu_result == 8'd0, alu_carry, alu_ovf, alu_result[7]};
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_err_d    = rsp_err_q;
      unique case (state_q)
         StIdle: begin
            if (grant0 || grant1) begin
               a_d          = grant1 ? bus.req1_a  : bus.req0_a;
               b_d          = grant1 ? bus.req1_b  : bus.req0_b;
               op_d         = grant1 ? bus.req1_op : bus.req0_op;
               id_d         = grant1;
               last_grant_d = grant1;
               state_d      = StExec;
            end
         end
         StExec: begin
            rsp_result_d = alu_result;
            rsp_flags_d  = alu_flags;
            rsp_err_d    = alu_err;
            rsp_id_d     = id_q;
            rsp_valid_d  = 1'b1;
            state_d      = StResp;
         end
         StResp: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         id_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         id_q         <= id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.rsp_err    = rsp_err_q;
   assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance carries most scenarios, a fixed-
// priority instance is checked for starvation of req1 under constant contention.
module tb_alu_arbiter;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic rr_busy, fp_busy;

   alu_arbiter_if rr_if ();
   alu_arbiter_if fp_if ();

   alu_arbiter #(.FIXED_PRIORITY(1'b0), .LEGAL_OP_MAX(2)) u_rr (
      .clk   (clk),
      .reset (reset),
      .bus   (rr_if.slave),
      .busy  (rr_busy)
   );

   alu_arbiter #(.FIXED_PRIORITY(1'b1), .LEGAL_OP_MAX(2)) u_fp (
      .clk   (clk),
      .reset (reset),
      .bus   (fp_if.slave),
      .busy  (fp_busy)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   logic mdl_last;

   logic [2:0] t_op  [4] = '{3'd1, 3'd1, 3'd2, 3'd0};
   logic [7:0] t_a   [4] = '{8'd129, 8'd120, 8'd100, 8'h33};
   logic [7:0] t_b   [4] = '{8'd200, 8'd11, 8'd100, 8'h80};
   logic [7:0] t_res [4] = '{8'd73, 8'd131, 8'd0, 8'h80};
   logic [3:0] t_flg [4] = '{4'b0110, 4'b0011, 4'b1100, 4'b0001};

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Returns {err, zero, carry, overflow, sign, result[7:0]} from integer arithmetic.
   function automatic logic [12:0] alu_model(logic [2:0] op, logic [7:0] a, logic [7:0] b);
      int         ua, ub, sa, sb, r, s;
      logic       c, v;
      logic [7:0] res;
      ua = int'(a);
      ub = int'(b);
      sa = a[7] ? ua - 256 : ua;
      sb = b[7] ? ub - 256 : ub;
      if (op > 3'd2) return 13'h1000;
      if (op == 3'd0) begin
         res = b;
         c   = 1'b0;
         v   = 1'b0;
      end else if (op == 3'd1) begin
         r   = ua + ub;
         res = 8'(r % 256);
         c   = (r > 255);
         s   = sa + sb;
         v   = (s > 127) || (s < -128);
      end else begin
         r   = ua - ub;
         res = 8'((r + 256) % 256);
         c   = (ua >= ub);
         s   = sa - sb;
         v   = (s > 127) || (s < -128);
      end
      return {1'b0, res == 8'd0, c, v, res[7], res};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rr_if.req0_valid = 1'b0; rr_if.req0_a = '0; rr_if.req0_b = '0; rr_if.req0_op = '0;
      rr_if.req1_valid = 1'b0; rr_if.req1_a = '0; rr_if.req1_b = '0; rr_if.req1_op = '0;
      rr_if.rsp_ready  = 1'b0;
      fp_if.req0_valid = 1'b0; fp_if.req0_a = '0; fp_if.req0_b = '0; fp_if.req0_op = '0;
      fp_if.req1_valid = 1'b0; fp_if.req1_a = '0; fp_if.req1_b = '0; fp_if.req1_op = '0;
      fp_if.rsp_ready  = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      idle_inputs();
      step();
      step();
      reset    = 1'b0;
      mdl_last = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      n_checks++;
      if ({rr_if.rsp_valid, rr_if.rsp_id, rr_if.rsp_result, rr_if.rsp_flags, rr_if.rsp_err,
           rr_busy} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0000", {rr_if.rsp_valid, rr_if.rsp_id,
                  rr_if.rsp_result, rr_if.rsp_flags, rr_if.rsp_err, rr_busy});
      end
      rr_if.req0_valid = 1'b1; rr_if.req0_a = 8'd1; rr_if.req0_b = 8'd2; rr_if.req0_op = 3'd1;
      rr_if.rsp_ready  = 1'b1;
      step();
      @(negedge clk);
      n_checks++;
      if (rr_busy !== 1'b1 || rr_if.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pre_exec: busy=%b rsp_valid=%b expected 1 0", rr_busy,
                  rr_if.rsp_valid);
      end
      reset = 1'b1;
      step();
      @(negedge clk);
      n_checks++;
      if ({rr_if.rsp_valid, rr_if.rsp_id, rr_if.rsp_result, rr_if.rsp_flags, rr_if.rsp_err,
           rr_busy} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_mid_exec: got %h expected 0000", {rr_if.rsp_valid, rr_if.rsp_id,
                  rr_if.rsp_result, rr_if.rsp_flags, rr_if.rsp_err, rr_busy});
      end
      step();
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rr_if.req0_ready !== 1'b1 || rr_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_ready: ready0=%b busy=%b expected 1 0", rr_if.req0_ready,
                  rr_busy);
      end
      idle_inputs();
   endtask

   task automatic test_basic_add();
      apply_reset();
      rr_if.req0_valid = 1'b1; rr_if.req0_a = 8'd1; rr_if.req0_b = 8'd2; rr_if.req0_op = 3'd1;
      rr_if.rsp_ready  = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({rr_if.req0_ready, rr_if.req1_ready, rr_busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL basic_accept: ready0,ready1,busy=%b expected 100",
                  {rr_if.req0_ready, rr_if.req1_ready, rr_busy});
      end
      step();
      rr_if.req0_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rr_busy !== 1'b1 || rr_if.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_exec: busy=%b rsp_valid=%b expected 1 0", rr_busy, rr_if.rsp_valid);
      end
      step();
      @(negedge clk);
      n_checks++;
      if ({rr_if.rsp_valid, rr_if.rsp_id, rr_if.rsp_result, rr_if.rsp_flags, rr_if.rsp_err,
           rr_busy} !== {1'b1, 1'b0, 8'd3, 4'b0000, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL basic_resp: valid=%b id=%b res=%0d flags=%b err=%b busy=%b expected 1 0 3 0000 0 1",
                  rr_if.rsp_valid, rr_if.rsp_id, rr_if.rsp_result, rr_if.rsp_flags,
                  rr_if.rsp_err, rr_busy);
      end
      step();
      @(negedge clk);
      n_checks++;
      if (rr_busy !== 1'b0 || rr_if.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done: busy=%b rsp_valid=%b expected 0 0", rr_busy, rr_if.rsp_valid);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_round_robin();
      int          next_free = 0;
      int          fp_acc    = 0;
      logic        exp_acc, exp_id;
      int          q_cyc[$];
      logic        q_id[$];
      logic [7:0]  q_res[$];
      logic [12:0] m;
      apply_reset();
      rr_if.req0_valid = 1'b1; rr_if.req0_a = 8'd10; rr_if.req0_b = 8'd20; rr_if.req0_op = 3'd1;
      rr_if.req1_valid = 1'b1; rr_if.req1_a = 8'd50; rr_if.req1_b = 8'd8;  rr_if.req1_op = 3'd2;
      rr_if.rsp_ready  = 1'b1;
      fp_if.req0_valid = 1'b1; fp_if.req0_a = 8'd1;  fp_if.req0_b = 8'd1;  fp_if.req0_op = 3'd1;
      fp_if.req1_valid = 1'b1; fp_if.req1_a = 8'd2;  fp_if.req1_b = 8'd2;  fp_if.req1_op = 3'd1;
      fp_if.rsp_ready  = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         exp_acc = (cyc >= next_free);
         exp_id  = !mdl_last;
         n_checks++;
         if (rr_if.req0_ready !== (exp_acc && !exp_id) || rr_if.req1_ready !== (exp_acc && exp_id))
         begin
            n_fail++;
            $display("FAIL rr_grant cyc%0d: ready0=%b ready1=%b expected %b %b", cyc,
                     rr_if.req0_ready, rr_if.req1_ready, exp_acc && !exp_id, exp_acc && exp_id);
         end
         if (exp_acc) begin
            m = exp_id ? alu_model(3'd2, 8'd50, 8'd8) : alu_model(3'd1, 8'd10, 8'd20);
            q_cyc.push_back(cyc + 2);
            q_id.push_back(exp_id);
            q_res.push_back(m[7:0]);
            mdl_last  = exp_id;
            next_free = cyc + 3;
         end
         n_checks++;
         if (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
            if (rr_if.rsp_valid !== 1'b1 || rr_if.rsp_id !== q_id[0] ||
                rr_if.rsp_result !== q_res[0]) begin
               n_fail++;
               $display("FAIL rr_resp cyc%0d: valid=%b id=%b res=%0d expected 1 %b %0d", cyc,
                        rr_if.rsp_valid, rr_if.rsp_id, rr_if.rsp_result, q_id[0], q_res[0]);
            end
            void'(q_cyc.pop_front());
            void'(q_id.pop_front());
            void'(q_res.pop_front());
         end else if (rr_if.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_resp cyc%0d: valid=%b expected 0", cyc, rr_if.rsp_valid);
         end
         n_checks++;
         if (fp_if.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fp_req1_ready cyc%0d: got %b expected 0", cyc, fp_if.req1_ready);
         end
         if (fp_if.req0_ready === 1'b1) fp_acc++;
         step();
      end
      n_checks++;
      if (fp_acc != 4) begin
         n_fail++;
         $display("FAIL fp_accepts: got %0d expected 4", fp_acc);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_backpressure();
      logic [12:0] m;
      apply_reset();
      m = alu_model(3'd1, 8'd5, 8'd6);
      rr_if.req0_valid = 1'b1; rr_if.req0_a = 8'd5; rr_if.req0_b = 8'd6; rr_if.req0_op = 3'd1;
      @(negedge clk);
      n_checks++;
      if (rr_if.req0_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_accept: ready0=%b expected 1", rr_if.req0_ready);
      end
      step();
      rr_if.req0_a = 8'd3; rr_if.req0_b = 8'd4; rr_if.req0_op = 3'd1;
      rr_if.req1_valid = 1'b1; rr_if.req1_a = 8'd9; rr_if.req1_b = 8'd1; rr_if.req1_op = 3'd2;
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({rr_if.rsp_valid, rr_if.rsp_id, rr_if.rsp_err, rr_if.rsp_flags, rr_if.rsp_result,
              rr_if.req0_ready, rr_if.req1_ready} !== {1'b1, 1'b0, m[12:0], 2'b00}) begin
            n_fail++;
            $display("FAIL bp_hold%0d: valid=%b id=%b err=%b flags=%b res=%0d rdy=%b%b expected 1 0 %b %b %0d 00",
                     i, rr_if.rsp_valid, rr_if.rsp_id, rr_if.rsp_err, rr_if.rsp_flags,
                     rr_if.rsp_result, rr_if.req0_ready, rr_if.req1_ready, m[12], m[11:8], m[7:0]);
         end
         step();
      end
      rr_if.rsp_ready = 1'b1;
      step();
      @(negedge clk);
      n_checks++;
      if ({rr_if.rsp_valid, rr_busy, rr_if.req0_ready, rr_if.req1_ready} !== 4'b0001) begin
         n_fail++;
         $display("FAIL bp_release: valid,busy,rdy0,rdy1=%b expected 0001",
                  {rr_if.rsp_valid, rr_busy, rr_if.req0_ready, rr_if.req1_ready});
      end
      step();
      rr_if.req0_valid = 1'b0;
      rr_if.req1_valid = 1'b0;
      m = alu_model(3'd2, 8'd9, 8'd1);
      step();
      @(negedge clk);
      n_checks++;
      if ({rr_if.rsp_valid, rr_if.rsp_id, rr_if.rsp_err, rr_if.rsp_flags, rr_if.rsp_result} !==
          {1'b1, 1'b1, m}) begin
         n_fail++;
         $display("FAIL bp_next: valid=%b id=%b err=%b flags=%b res=%0d expected 1 1 %b %b %0d",
                  rr_if.rsp_valid, rr_if.rsp_id, rr_if.rsp_err, rr_if.rsp_flags,
                  rr_if.rsp_result, m[12], m[11:8], m[7:0]);
      end
      step();
      idle_inputs();
   endtask

   task automatic test_flags();
      apply_reset();
      rr_if.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rr_if.req0_valid = 1'b1;
         rr_if.req0_a     = t_a[i];
         rr_if.req0_b     = t_b[i];
         rr_if.req0_op    = t_op[i];
         step();
         rr_if.req0_valid = 1'b0;
         step();
         @(negedge clk);
         n_checks++;
         if ({rr_if.rsp_valid, rr_if.rsp_result, rr_if.rsp_flags, rr_if.rsp_err} !==
             {1'b1, t_res[i], t_flg[i], 1'b0}) begin
            n_fail++;
            $display("FAIL flags_vec%0d: valid=%b res=%0d flags=%b err=%b expected 1 %0d %b 0", i,
                     rr_if.rsp_valid, rr_if.rsp_result, rr_if.rsp_flags, rr_if.rsp_err,
                     t_res[i], t_flg[i]);
         end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_illegal_op();
      apply_reset();
      rr_if.req1_valid = 1'b1; rr_if.req1_a = 8'd7; rr_if.req1_b = 8'd9; rr_if.req1_op = 3'd5;
      rr_if.rsp_ready  = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({rr_if.req0_ready, rr_if.req1_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL illegal_accept: rdy0,rdy1=%b expected 01",
                  {rr_if.req0_ready, rr_if.req1_ready});
      end
      step();
      rr_if.req1_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rr_if.rsp_valid !== 1'b0 || rr_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL illegal_exec: valid=%b busy=%b expected 0 1", rr_if.rsp_valid, rr_busy);
      end
      step();
      @(negedge clk);
      n_checks++;
      if ({rr_if.rsp_valid, rr_if.rsp_id, rr_if.rsp_err, rr_if.rsp_flags, rr_if.rsp_result} !==
          {1'b1, 1'b1, 1'b1, 4'b0000, 8'd0}) begin
         n_fail++;
         $display("FAIL illegal_resp: valid=%b id=%b err=%b flags=%b res=%0d expected 1 1 1 0000 0",
                  rr_if.rsp_valid, rr_if.rsp_id, rr_if.rsp_err, rr_if.rsp_flags,
                  rr_if.rsp_result);
      end
      step();
      idle_inputs();
   endtask

   task automatic test_random();
      logic        v0, v1, w;
      logic [2:0]  op0, op1;
      logic [7:0]  a0, b0, a1, b1;
      logic [12:0] m;
      int          stall;
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         v0  = 1'($urandom_range(0, 1));
         v1  = 1'($urandom_range(0, 1));
         if (!v0 && !v1) v1 = 1'b1;
         op0 = 3'($urandom_range(0, 7)); a0 = 8'($urandom); b0 = 8'($urandom);
         op1 = 3'($urandom_range(0, 7)); a1 = 8'($urandom); b1 = 8'($urandom);
         rr_if.req0_valid = v0; rr_if.req0_a = a0; rr_if.req0_b = b0; rr_if.req0_op = op0;
         rr_if.req1_valid = v1; rr_if.req1_a = a1; rr_if.req1_b = b1; rr_if.req1_op = op1;
         w = (v0 && v1) ? !mdl_last : v1;
         m = w ? alu_model(op1, a1, b1) : alu_model(op0, a0, b0);
         @(negedge clk);
         n_checks++;
         if ({rr_if.req0_ready, rr_if.req1_ready} !== {!w, w}) begin
            n_fail++;
            $display("FAIL rand%0d_grant: rdy0,rdy1=%b expected %b", i,
                     {rr_if.req0_ready, rr_if.req1_ready}, {!w, w});
         end
         step();
         mdl_last = w;
         rr_if.req0_valid = 1'b0;
         rr_if.req1_valid = 1'b0;
         @(negedge clk);
         n_checks++;
         if (rr_if.rsp_valid !== 1'b0 || rr_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rand%0d_exec: valid=%b busy=%b expected 0 1", i, rr_if.rsp_valid,
                     rr_busy);
         end
         step();
         stall = $urandom_range(0, 3);
         for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            n_checks++;
            if ({rr_if.rsp_valid, rr_if.rsp_id, rr_if.rsp_err, rr_if.rsp_flags,
                 rr_if.rsp_result} !== {1'b1, w, m}) begin
               n_fail++;
               $display("FAIL rand%0d_resp%0d: valid=%b id=%b err=%b flags=%b res=%0d expected 1 %b %b %b %0d",
                        i, s, rr_if.rsp_valid, rr_if.rsp_id, rr_if.rsp_err, rr_if.rsp_flags,
                        rr_if.rsp_result, w, m[12], m[11:8], m[7:0]);
            end
            if (s == stall) rr_if.rsp_ready = 1'b1;
            step();
         end
         rr_if.rsp_ready = 1'b0;
         @(negedge clk);
         n_checks++;
         if (rr_if.rsp_valid !== 1'b0 || rr_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rand%0d_idle: valid=%b busy=%b expected 0 0", i, rr_if.rsp_valid,
                     rr_busy);
         end
         step();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_basic_add();
      test_round_robin();
      test_backpressure();
      test_flags();
      test_illegal_op();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
